// File: rtl/serializer_pkg.sv
// Shared definitions for the FIFO word serializer: FSM encoding and parity helper.
package serializer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   // Widest word the parity helper accepts; narrower words are zero-extended,
   // which leaves the XOR reduction unchanged.
   localparam int PAR_W = 64;

   function automatic logic odd_parity(input logic [PAR_W-1:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period divider: counts 0..BIT_DIV-1 and flags the first and last clock of each period.
module bit_tick_gen #(
   parameter int BIT_DIV = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic tick_first,
   output logic tick_last
);

   localparam int            CW       = $clog2(BIT_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(BIT_DIV - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || cnt == CNT_LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick_first = (cnt == '0);
   assign tick_last  = (cnt == CNT_LAST);

endmodule

// File: rtl/fifo_word_serializer.sv
// Pops words from a fifo_simple read port and shifts them out MSB-first with optional odd parity.
module fifo_word_serializer
   import serializer_pkg::*;
#(
   parameter int DW       = 16,
   parameter int BIT_DIV  = 8,
   parameter int PARITY   = 1,
   parameter int GAP_BITS = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable_i,
   input  logic          fifo_unempty_i,
   input  logic [DW-1:0] fifo_data_i,
   output logic          fifo_r_req_o,
   output logic          tx_bit_o,
   output logic          tx_bit_stb_o,
   output logic          tx_active_o,
   output logic          word_done_o
);

   localparam int            FLEN     = DW + PARITY;
   localparam int            IW       = $clog2(FLEN);
   localparam logic [IW-1:0] IDX_LAST = IW'(FLEN - 1);
   localparam int            GAP_CLKS = GAP_BITS * BIT_DIV;
   localparam int            GW       = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

   state_t          state;
   logic [FLEN-1:0] sr;
   logic [IW-1:0]   idx;
   logic [GW-1:0]   gap_cnt;
   logic            tick_first;
   logic            tick_last;
   logic            tick_clear;
   logic            frame_end;
   logic            pop;
   logic [DW:0]     load_ext;
   logic [FLEN-1:0] load_word;

   assign tick_clear = (state != ST_SHIFT);

   bit_tick_gen #(.BIT_DIV(BIT_DIV)) u_tick (
      .clk        (clk),
      .rst        (rst),
      .clear      (tick_clear),
      .tick_first (tick_first),
      .tick_last  (tick_last)
   );

   // With PARITY=0 the part-select drops the parity bit and keeps only the data word.
   assign load_ext  = {fifo_data_i, odd_parity(PAR_W'(fifo_data_i))};
   assign load_word = load_ext[DW -: FLEN];
   assign frame_end = (state == ST_SHIFT) && tick_last && (idx == IDX_LAST);

   // The final gap clock may pop directly so the idle span is exactly GAP_BITS periods.
   always_comb begin
      // NOTE: default first so no path through this block leaves pop unassigned (no latch).
      pop = 1'b0;
      if (!rst && enable_i && fifo_unempty_i) begin
         case (state)
            ST_IDLE:  pop = 1'b1;
            ST_SHIFT: pop = frame_end && (GAP_BITS == 0);
            ST_GAP:   pop = (gap_cnt == GAP_LAST);
            default:  pop = 1'b0;
         endcase
      end
   end

   assign fifo_r_req_o = pop;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         sr      <= '0;
         idx     <= '0;
         gap_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  sr    <= load_word;
                  idx   <= '0;
                  state <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (tick_last) begin
                  if (idx != IDX_LAST) begin
                     idx <= idx + IW'(1);
                     sr  <= sr << 1;
                  end else if (pop) begin
                     sr  <= load_word;
                     idx <= '0;
                  end else if (GAP_BITS > 0) begin
                     gap_cnt <= '0;
                     state   <= ST_GAP;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_GAP: begin
               if (pop) begin
                  sr    <= load_word;
                  idx   <= '0;
                  state <= ST_SHIFT;
               end else if (gap_cnt == GAP_LAST) begin
                  state <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Outputs decode flop state only, so reset clears them immediately.
   assign tx_active_o  = (state == ST_SHIFT);
   assign tx_bit_o     = tx_active_o & sr[FLEN-1];
   assign tx_bit_stb_o = tx_active_o & tick_first;
   assign word_done_o  = frame_end;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Directed bench: three serializer configurations, each fed by a small behavioural FIFO.
module tb_fifo_word_serializer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   int   sel = 0;
   int   total = 0;
   int   bad   = 0;
   int   viol  = 0;

   logic [15:0] mem [3][16];
   int          rd [3] = '{0, 0, 0};
   int          wr [3] = '{0, 0, 0};

   logic        a_ue, g_ue, n_ue;
   logic [15:0] a_data, g_data;
   logic [7:0]  n_data;
   logic        a_req, a_bit, a_stb, a_act, a_done;
   logic        g_req, g_bit, g_stb, g_act, g_done;
   logic        n_req, n_bit, n_stb, n_act, n_done;
   logic        s_req, s_bit, s_stb, s_act, s_done;

   always #5 clk = ~clk;

   assign a_ue   = (rd[0] != wr[0]);
   assign g_ue   = (rd[1] != wr[1]);
   assign n_ue   = (rd[2] != wr[2]);
   assign a_data = mem[0][rd[0] % 16];
   assign g_data = mem[1][rd[1] % 16];
   assign n_data = mem[2][rd[2] % 16][7:0];

   fifo_word_serializer #(.DW(16), .BIT_DIV(4), .PARITY(1), .GAP_BITS(0)) u_a (
      .clk(clk), .rst(rst), .enable_i(en), .fifo_unempty_i(a_ue), .fifo_data_i(a_data),
      .fifo_r_req_o(a_req), .tx_bit_o(a_bit), .tx_bit_stb_o(a_stb), .tx_active_o(a_act),
      .word_done_o(a_done));

   fifo_word_serializer #(.DW(16), .BIT_DIV(4), .PARITY(1), .GAP_BITS(2)) u_g (
      .clk(clk), .rst(rst), .enable_i(en), .fifo_unempty_i(g_ue), .fifo_data_i(g_data),
      .fifo_r_req_o(g_req), .tx_bit_o(g_bit), .tx_bit_stb_o(g_stb), .tx_active_o(g_act),
      .word_done_o(g_done));

   fifo_word_serializer #(.DW(8), .BIT_DIV(2), .PARITY(0), .GAP_BITS(0)) u_n (
      .clk(clk), .rst(rst), .enable_i(en), .fifo_unempty_i(n_ue), .fifo_data_i(n_data),
      .fifo_r_req_o(n_req), .tx_bit_o(n_bit), .tx_bit_stb_o(n_stb), .tx_active_o(n_act),
      .word_done_o(n_done));

   // FIFO read side: a pop advances the head on the clock edge that ends the r_req cycle.
   always @(posedge clk) begin
      if (a_req) begin if (!a_ue) viol++; rd[0] <= rd[0] + 1; end
      if (g_req) begin if (!g_ue) viol++; rd[1] <= rd[1] + 1; end
      if (n_req) begin if (!n_ue) viol++; rd[2] <= rd[2] + 1; end
   end

   always_comb begin
      case (sel)
         0:       {s_req, s_bit, s_stb, s_act, s_done} = {a_req, a_bit, a_stb, a_act, a_done};
         1:       {s_req, s_bit, s_stb, s_act, s_done} = {g_req, g_bit, g_stb, g_act, g_done};
         default: {s_req, s_bit, s_stb, s_act, s_done} = {n_req, n_bit, n_stb, n_act, n_done};
      endcase
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input int q, input logic [15:0] w);
      mem[q][wr[q] % 16] = w;
      wr[q] = wr[q] + 1;
   endtask

   task automatic flush(input int q);
      wr[q] = rd[q];
   endtask

   // Returns at the negedge where r_req is seen (the pop cycle).
   task automatic wait_req(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (s_req) begin
            ok = 1'b1;
            break;
         end
      end
      check({name, "_req_seen"}, 32'(ok), 32'd1);
   endtask

   // Samples one whole frame starting on the clock after the pop cycle.
   task automatic frame(input string name, input int flen, input int bd, input logic [31:0] exp,
                        output int act_n, output bit req_end);
      logic [31:0] got;
      int          stbs, done_at, holds;
      logic        prev;
      got = '0; stbs = 0; done_at = 0; holds = 0; prev = 1'b0;
      act_n = 0; req_end = 1'b0;
      for (int k = 1; k <= flen * bd; k++) begin
         @(negedge clk);
         if (s_act) act_n++;
         if (s_stb) begin
            got = {got[30:0], s_bit};
            stbs++;
         end else if (s_bit !== prev) begin
            holds++;
         end
         prev = s_bit;
         if (s_done) done_at = k;
         if (k == flen * bd) req_end = s_req;
      end
      check({name, "_bits"},    got,     exp);
      check({name, "_strobes"}, stbs,    flen);
      check({name, "_done_at"}, done_at, flen * bd);
      check({name, "_active"},  act_n,   flen * bd);
      check({name, "_hold"},    holds,   0);
   endtask

   typedef struct {
      logic [15:0] word;
      logic [31:0] frame;
   } vec_t;

   vec_t vecs [6];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   act0, act1, n, idle, stbs, p0;
      bit   req_end, done;
      logic [31:0] got;

      // {data, odd parity} frames, hand-computed.
      vecs[0] = '{16'hA5C3, 32'h14B87};
      vecs[1] = '{16'hFFFF, 32'h1FFFF};
      vecs[2] = '{16'h0001, 32'h00002};
      vecs[3] = '{16'h0000, 32'h00001};
      vecs[4] = '{16'h8000, 32'h10000};
      vecs[5] = '{16'h1234, 32'h02468};

      repeat (2) @(negedge clk);
      check("rst_a_outputs", {a_req, a_bit, a_stb, a_act, a_done}, 5'b0);
      check("rst_g_outputs", {g_req, g_bit, g_stb, g_act, g_done}, 5'b0);
      check("rst_n_outputs", {n_req, n_bit, n_stb, n_act, n_done}, 5'b0);
      en = 1'b1;
      push(0, 16'h1111);
      #1;
      check("rst_no_pop", a_req, 1'b0);
      flush(0);
      sync();
      rst = 1'b0;

      // Single words from the vector table.
      sel = 0;
      foreach (vecs[v]) begin
         sync();
         push(0, vecs[v].word);
         wait_req($sformatf("vec%0d", v));
         frame($sformatf("vec%0d", v), 17, 4, vecs[v].frame, act0, req_end);
         @(negedge clk);
         check($sformatf("vec%0d_idle_after", v), s_act, 1'b0);
      end

      // Back-to-back frames with no gap.
      sync();
      p0 = rd[0];
      push(0, 16'hFFFF);
      push(0, 16'h0001);
      wait_req("b2b");
      frame("b2b0", 17, 4, 32'h1FFFF, act0, req_end);
      check("b2b_req_on_done", req_end, 1'b1);
      frame("b2b1", 17, 4, 32'h00002, act1, req_end);
      check("b2b_active_run", act0 + act1, 136);
      check("b2b_pops", rd[0] - p0, 2);

      // Gap insertion between two frames.
      sel = 1;
      sync();
      push(1, 16'hA5C3);
      push(1, 16'h1234);
      wait_req("gap");
      frame("gap0", 17, 4, 32'h14B87, act0, req_end);
      idle = 0;
      done = 1'b0;
      for (int i = 0; i < 50 && !done; i++) begin
         @(negedge clk);
         if (!s_act) idle++;
         if (s_req) done = 1'b1;
      end
      check("gap_idle_clocks", idle, 8);
      frame("gap1", 17, 4, 32'h02468, act0, req_end);

      // Enable low with data waiting, then enable high with an empty FIFO.
      sel = 0;
      sync();
      en = 1'b0;
      push(0, 16'h5555);
      n = 0;
      repeat (20) begin @(negedge clk); if (s_req) n++; end
      check("disabled_no_req", n, 0);
      flush(0);
      en = 1'b1;
      n = 0;
      repeat (20) begin @(negedge clk); if (s_req) n++; end
      check("empty_no_req", n, 0);

      // Enable dropped at bit 5: frame completes, no second pop.
      sync();
      p0 = rd[0];
      push(0, 16'h00FF);
      push(0, 16'hFF00);
      wait_req("endrop");
      got = '0; stbs = 0; done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge clk);
         if (s_stb) begin
            got = {got[30:0], s_bit};
            stbs++;
            if (stbs == 6) en = 1'b0;
         end
         if (s_done) done = 1'b1;
      end
      check("endrop_bits", got, 32'h001FF);
      check("endrop_strobes", stbs, 17);
      n = 0;
      repeat (20) begin @(negedge clk); if (s_req) n++; end
      check("endrop_no_req", n, 0);
      check("endrop_pops", rd[0] - p0, 1);
      flush(0);
      en = 1'b1;

      // Reset at bit 7, then restart on the next word.
      sync();
      push(0, 16'hA5C3);
      push(0, 16'h8000);
      wait_req("rstmid");
      stbs = 0;
      for (int k = 0; k < 200 && stbs < 8; k++) begin
         @(negedge clk);
         if (s_stb) stbs++;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rstmid_outputs", {a_req, a_bit, a_stb, a_act, a_done}, 5'b0);
      @(posedge clk);
      #2;
      rst = 1'b0;
      wait_req("rstmid_restart");
      frame("rstmid_frame", 17, 4, 32'h10000, act0, req_end);

      // No-parity 8-bit configuration.
      sel = 2;
      sync();
      push(2, 16'h0081);
      wait_req("np0");
      frame("np0", 8, 2, 32'h81, act0, req_end);
      sync();
      push(2, 16'h003C);
      wait_req("np1");
      frame("np1", 8, 2, 32'h3C, act0, req_end);

      check("req_while_empty", viol, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
